// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration states and port identifiers.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a single-port data memory.
// Memory controls are combinational from the grant; read data comes back registered one cycle later.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  port_e                 last_q, rsel_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  gnt_valid;
  port_e                 gnt_port;
  port_e                 owner, other;
  logic                  owner_req, other_req;
  logic                  gnt_ok;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_valid = 1'b0;
    gnt_port  = PORT0;
    owner     = (state_q == OWN1) ? PORT1 : PORT0;
    other     = (state_q == OWN1) ? PORT0 : PORT1;
    owner_req = (state_q == OWN1) ? m1_req : m0_req;
    other_req = (state_q == OWN1) ? m0_req : m1_req;

    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt_valid = 1'b1;
          gnt_port  = (last_q == PORT0) ? PORT1 : PORT0;
        end else if (m0_req || m1_req) begin
          gnt_valid = 1'b1;
          gnt_port  = m1_req ? PORT1 : PORT0;
        end
        if (gnt_valid) begin
          state_d = (gnt_port == PORT1) ? OWN1 : OWN0;
          cnt_d   = CNT_ONE;
        end
      end
      OWN0, OWN1: begin
        if (owner_req && (!other_req || cnt_q < CNT_MAX)) begin
          gnt_valid = 1'b1;
          gnt_port  = owner;
          cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else if (other_req) begin
          // Burst exhausted or owner released: hand over to the waiting port.
          gnt_valid = 1'b1;
          gnt_port  = other;
          state_d   = (other == PORT1) ? OWN1 : OWN0;
          cnt_d     = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sel_we    = (gnt_port == PORT1) ? m1_we    : m0_we;
  assign sel_addr  = (gnt_port == PORT1) ? m1_addr  : m0_addr;
  assign sel_wdata = (gnt_port == PORT1) ? m1_wdata : m0_wdata;

  // Outputs are held quiet for the whole time reset is asserted, not just at the edge.
  assign gnt_ok    = gnt_valid & ~reset;
  assign m0_gnt    = gnt_ok & (gnt_port == PORT0);
  assign m1_gnt    = gnt_ok & (gnt_port == PORT1);
  assign mem_write = gnt_ok & sel_we;
  assign mem_read  = gnt_ok & ~sel_we;
  assign mem_addr  = gnt_ok ? sel_addr  : '0;
  assign mem_wdata = gnt_ok ? sel_wdata : '0;

  assign m0_rvalid = rvalid_q & (rsel_q == PORT0);
  assign m1_rvalid = rvalid_q & (rsel_q == PORT1);
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= PORT1;
      rsel_q   <= PORT0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt_valid & ~sel_we;
      if (gnt_valid) begin
        last_q <= gnt_port;
      end
      if (gnt_valid && !sel_we) begin
        rdata_q <= mem_rdata;
        rsel_q  <= gnt_port;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed grant expectations plus a read-response scoreboard.
module tb_data_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        mem_write, mem_read;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          port;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [63:0] ref_mem [0:31];

  // Memory model: asynchronous read, synchronous write, 32 words indexed by addr[7:3].
  logic [63:0] mem [0:31];
  bit          written [0:31];
  logic [4:0]  mem_idx;

  function automatic logic [63:0] init_val(input int i);
    if (i == 2) return 64'hA5;
    return 64'h5000 + 64'(i) * 64'h0101_0101;
  endfunction

  assign mem_idx   = mem_addr[7:3];
  assign mem_rdata = written[mem_idx] ? mem[mem_idx] : init_val(int'(mem_idx));

  always @(posedge clk_in) begin
    if (mem_write) begin
      mem[mem_idx]     <= mem_wdata;
      written[mem_idx] <= 1'b1;
    end
  end

  always #5 clk_in = ~clk_in;

  data_mem_arbiter dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  // One clock cycle: check last cycle's response, check this cycle's grant, then advance past the edge.
  task automatic cycle(input int exp_port, input string tag);
    rd_exp_t     e;
    logic        we;
    logic [63:0] addr, wdata;
    @(negedge clk_in);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " m0_rvalid"}, 64'(m0_rvalid), 64'(e.port == 0));
      check({tag, " m1_rvalid"}, 64'(m1_rvalid), 64'(e.port == 1));
      check({tag, " rdata"}, (e.port == 0) ? m0_rdata : m1_rdata, e.data);
    end else begin
      check({tag, " no m0_rvalid"}, 64'(m0_rvalid), 64'd0);
      check({tag, " no m1_rvalid"}, 64'(m1_rvalid), 64'd0);
    end
    check({tag, " m0_gnt"}, 64'(m0_gnt), 64'(exp_port == 0));
    check({tag, " m1_gnt"}, 64'(m1_gnt), 64'(exp_port == 1));
    if (exp_port >= 0) begin
      we    = (exp_port == 1) ? m1_we    : m0_we;
      addr  = (exp_port == 1) ? m1_addr  : m0_addr;
      wdata = (exp_port == 1) ? m1_wdata : m0_wdata;
      check({tag, " mem_write"}, 64'(mem_write), 64'(we));
      check({tag, " mem_read"}, 64'(mem_read), 64'(!we));
      check({tag, " mem_addr"}, mem_addr, addr);
      if (we) begin
        check({tag, " mem_wdata"}, mem_wdata, wdata);
        ref_mem[addr[7:3]] = wdata;
      end else begin
        sb.push_back('{port: exp_port, data: ref_mem[addr[7:3]]});
      end
    end else begin
      check({tag, " idle mem_write"}, 64'(mem_write), 64'd0);
      check({tag, " idle mem_read"}, 64'(mem_read), 64'd0);
      check({tag, " idle mem_addr"}, mem_addr, 64'd0);
      check({tag, " idle mem_wdata"}, mem_wdata, 64'd0);
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    reset = 1'b1;
    set0(1'b1, 1'b0, 64'h10, 64'h0);
    set1(1'b0, 1'b0, 64'h0, 64'h0);

    // A request during reset must not leak through to any output.
    cycle(-1, "in_reset");
    reset = 1'b0;

    // Tie in the first cycle after reset goes to m0; m1 follows when m0 drops.
    set0(1'b1, 1'b0, 64'h10, 64'h0);
    set1(1'b1, 1'b0, 64'h18, 64'h0);
    cycle(0, "tie_m0");
    set0(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(1, "handoff_m1");
    set1(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "drain_tie");

    // Write then read back on m1; the write itself yields no response.
    set1(1'b1, 1'b1, 64'h20, 64'hDEAD_BEEF);
    cycle(1, "m1_write");
    set1(1'b1, 1'b0, 64'h20, 64'h0);
    cycle(1, "m1_readback");
    set1(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "drain_wr");

    // Idle gap: m1 starts a fresh burst from IDLE with a count of one.
    set0(1'b1, 1'b0, 64'h10, 64'h0);
    cycle(0, "gap_m0");
    set0(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "gap_idle");
    set1(1'b1, 1'b0, 64'h40, 64'h0);
    cycle(1, "gap_m1");
    set0(1'b1, 1'b0, 64'h48, 64'h0);
    for (int i = 0; i < 7; i++) cycle(1, "gap_burst_m1");

    // Sustained contention: blocks of eight, m1 writing the word m0 reads.
    for (int i = 0; i < 32; i++) begin
      set1(1'b1, 1'b1, 64'h48, 64'h100 + 64'(i));
      cycle(((i / 8) % 2 == 0) ? 0 : 1, "burst");
    end
    set0(1'b0, 1'b0, 64'h0, 64'h0);
    set1(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "drain_burst");

    // Leave last = m0 so the post-reset tie shows last was reset to m1.
    set0(1'b1, 1'b0, 64'h10, 64'h0);
    cycle(0, "pre_reset_m0");
    set0(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "pre_reset_idle");

    // Reset asserted inside a read-grant cycle.
    set0(1'b1, 1'b0, 64'h18, 64'h0);
    @(negedge clk_in);
    check("midrd m0_gnt before reset", 64'(m0_gnt), 64'd1);
    check("midrd mem_read before reset", 64'(mem_read), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("midrd m0_gnt", 64'(m0_gnt), 64'd0);
    check("midrd m1_gnt", 64'(m1_gnt), 64'd0);
    check("midrd mem_read", 64'(mem_read), 64'd0);
    check("midrd mem_addr", mem_addr, 64'd0);
    check("midrd m0_rvalid", 64'(m0_rvalid), 64'd0);
    @(posedge clk_in);
    #1;
    check("midrd rvalid after edge", 64'(m0_rvalid | m1_rvalid), 64'd0);
    reset = 1'b0;
    set0(1'b1, 1'b0, 64'h10, 64'h0);
    set1(1'b1, 1'b0, 64'h18, 64'h0);
    cycle(0, "post_reset_tie");
    set0(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(1, "post_reset_m1");
    set1(1'b0, 1'b0, 64'h0, 64'h0);
    cycle(-1, "final_drain");
    cycle(-1, "final_idle");

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
